// File: rtl/ac_flush_sequencer.sv
// -----------------------------------------------------------------------------
// ac_flush_sequencer
//
// Termination controller for the arithmetic encoder. It counts finished
// symbols and, once the message ends (fixed symbol count reached or a forced
// end), stalls the encoder core. It then shifts the final code word out
// MSB-first over a valid/ready bit stream:
//   low[N], then e3_count copies of ~low[N], then low[N-1] .. low[0].
//
// Ports
//   sys_clk         rising-edge clock
//   sys_reset       asynchronous, active-low reset
//   sym_done        one-cycle pulse per finished symbol (low/e3_count valid)
//   low             encoder low register after the symbol (N+1 bits)
//   e3_count        pending underflow (E3) count after the symbol
//   force_end       pulse that ends the message early
//   enc_hold        stall to the encoder core while the flush is in progress
//   bit_out         serial code bit
//   bit_valid       bit_out is valid
//   bit_ready       downstream accepts the bit
//   bit_last        final bit of the message, qualified by bit_valid
//   terminate_flag  one-cycle pulse after the final bit is accepted
//   sym_count       symbols encoded in the current message
//
// NUM_SYMBOLS must lie in 1 .. 2**CNT_W-1.
// -----------------------------------------------------------------------------
module ac_flush_sequencer #(
  parameter int N           = 8,
  parameter int E3_W        = 7,
  parameter int NUM_SYMBOLS = 96,
  parameter int CNT_W       = 7
) (
  input  logic             sys_clk,
  input  logic             sys_reset,
  input  logic             sym_done,
  input  logic [N:0]       low,
  input  logic [E3_W-1:0]  e3_count,
  input  logic             force_end,
  output logic             enc_hold,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             bit_last,
  output logic             terminate_flag,
  output logic [CNT_W-1:0] sym_count
);

  // idx walks N-1 .. 0 through the remaining bits of low.
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  // Width able to address every bit of low_q without truncation.
  localparam int SEL_W = (N > 0) ? $clog2(N + 1) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SYMBOLS - 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(N - 1);
  localparam logic [E3_W-1:0]  REM_ONE  = E3_W'(1);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_MSB,
    ST_E3,
    ST_REM,
    ST_DONE
  } state_t;

  state_t            state_reg;
  logic [N:0]        low_q;
  logic [E3_W-1:0]   e3_q;
  logic [E3_W-1:0]   rem_reg;
  logic [IDX_W-1:0]  idx_reg;

  logic              capture;
  logic              handshake;
  logic [IDX_W-1:0]  idx_dec;
  logic [SEL_W-1:0]  sel_dec;

  // The message ends on the symbol that brings the count to NUM_SYMBOLS, or
  // on a forced end (with or without a symbol in the same cycle). Only
  // acted on in RUN.
  assign capture   = force_end | (sym_done & (sym_count == LAST_CNT));
  assign handshake = bit_valid & bit_ready;

  // Next index of the remainder phase; only used when idx_reg > 0, so the
  // decrement never wraps in practice.
  assign idx_dec   = idx_reg - 1'b1;
  assign sel_dec   = SEL_W'(idx_dec);

  // Single FSM process. Every output is a register loaded for the state being
  // entered, so bit_valid never depends combinationally on bit_ready and
  // bit_out holds while a bit waits for acceptance.
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_reg      <= ST_RUN;
      low_q          <= '0;
      e3_q           <= '0;
      rem_reg        <= '0;
      idx_reg        <= '0;
      enc_hold       <= 1'b0;
      bit_out        <= 1'b0;
      bit_valid      <= 1'b0;
      bit_last       <= 1'b0;
      terminate_flag <= 1'b0;
      sym_count      <= '0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          // A symbol arriving together with the end condition is still
          // counted, and its low/e3_count are the ones latched.
          if (sym_done) begin
            sym_count <= sym_count + 1'b1;
          end
          if (capture) begin
            low_q     <= low;
            e3_q      <= e3_count;
            state_reg <= ST_MSB;
            enc_hold  <= 1'b1;
            bit_valid <= 1'b1;
            bit_out   <= low[N];
            bit_last  <= 1'b0;
          end
        end

        ST_MSB: begin
          if (handshake) begin
            if (e3_q == '0) begin
              // No underflow bits pending: go straight to the remainder.
              state_reg <= ST_REM;
              idx_reg   <= IDX_TOP;
              bit_out   <= low_q[N-1];
              bit_last  <= (N == 1);
            end else begin
              state_reg <= ST_E3;
              rem_reg   <= e3_q;
              bit_out   <= ~low_q[N];
            end
          end
        end

        ST_E3: begin
          // bit_out already carries ~low_q[N]; only the count moves.
          if (handshake) begin
            if (rem_reg == REM_ONE) begin
              state_reg <= ST_REM;
              idx_reg   <= IDX_TOP;
              bit_out   <= low_q[N-1];
              bit_last  <= (N == 1);
            end else begin
              rem_reg <= rem_reg - 1'b1;
            end
          end
        end

        ST_REM: begin
          if (handshake) begin
            if (idx_reg == '0) begin
              state_reg      <= ST_DONE;
              bit_valid      <= 1'b0;
              bit_last       <= 1'b0;
              bit_out        <= 1'b0;
              terminate_flag <= 1'b1;
            end else begin
              idx_reg  <= idx_dec;
              bit_out  <= low_q[sel_dec];
              bit_last <= (idx_dec == '0);
            end
          end
        end

        ST_DONE: begin
          // One-cycle terminate pulse, then release the encoder core with
          // a fresh symbol count.
          state_reg      <= ST_RUN;
          terminate_flag <= 1'b0;
          enc_hold       <= 1'b0;
          sym_count      <= '0;
        end

        default: begin
          state_reg      <= ST_RUN;
          enc_hold       <= 1'b0;
          bit_valid      <= 1'b0;
          bit_last       <= 1'b0;
          bit_out        <= 1'b0;
          terminate_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ac_flush_sequencer.sv
// Bench for ac_flush_sequencer. The stimulus side computes the expected code
// bit stream for every message straight from the serialisation rule (MSB,
// e3 complement bits, remaining bits) and queues it; a monitor pops and
// compares on every accepted bit and checks the terminate pulse.
module tb_ac_flush_sequencer;

  localparam int N           = 8;
  localparam int E3_W        = 7;
  localparam int NUM_SYMBOLS = 96;
  localparam int CNT_W       = 7;
  localparam int LW          = N + 1;
  localparam int TIMEOUT     = 5000;

  logic             sys_clk = 1'b0;
  logic             sys_reset = 1'b0;
  logic             sym_done = 1'b0;
  logic [N:0]       low = '0;
  logic [E3_W-1:0]  e3_count = '0;
  logic             force_end = 1'b0;
  logic             enc_hold;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_ready = 1'b1;
  logic             bit_last;
  logic             terminate_flag;
  logic [CNT_W-1:0] sym_count;

  always #5 sys_clk = ~sys_clk;

  ac_flush_sequencer #(
    .N(N), .E3_W(E3_W), .NUM_SYMBOLS(NUM_SYMBOLS), .CNT_W(CNT_W)
  ) dut (
    .sys_clk(sys_clk),
    .sys_reset(sys_reset),
    .sym_done(sym_done),
    .low(low),
    .e3_count(e3_count),
    .force_end(force_end),
    .enc_hold(enc_hold),
    .bit_out(bit_out),
    .bit_valid(bit_valid),
    .bit_ready(bit_ready),
    .bit_last(bit_last),
    .terminate_flag(terminate_flag),
    .sym_count(sym_count)
  );

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   model_count = 0;
  int   hs_total = 0;
  bit   mon_en = 1'b0;
  bit   stall_en = 1'b0;

  // monitor state
  logic prev_stall = 1'b0;
  logic prev_bit = 1'b0;
  logic term_exp = 1'b0;
  exp_t mon_item;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected serial stream for a latched (low, e3) pair.
  function automatic void push_message(input logic [N:0] l, input int e);
    exp_t it;
    it.b = l[N];
    it.last = 1'b0;
    exp_q.push_back(it);
    for (int i = 0; i < e; i++) begin
      it.b = ~l[N];
      it.last = 1'b0;
      exp_q.push_back(it);
    end
    for (int i = N - 1; i >= 0; i--) begin
      it.b = l[i];
      it.last = (i == 0);
      exp_q.push_back(it);
    end
  endfunction

  task automatic cycle();
    @(posedge sys_clk);
    #1;
  endtask

  // Monitor: one line per accepted bit.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (!mon_en) begin
        prev_stall = 1'b0;
        term_exp = 1'b0;
      end else begin
        if (term_exp || terminate_flag) begin
          chk("terminate_flag", 32'(terminate_flag), 32'(term_exp));
          if (term_exp) $display("terminate_flag seen=%0d", terminate_flag);
        end
        term_exp = 1'b0;
        if (prev_stall) begin
          chk("stall_valid", 32'(bit_valid), 32'd1);
          chk("stall_bit", 32'(bit_out), 32'(prev_bit));
        end
        if (bit_valid && bit_ready) begin
          hs_total++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_bit: got bit %0d with no bit outstanding, required none", bit_out);
          end else begin
            mon_item = exp_q.pop_front();
            $display("bit: got=%0d exp=%0d last=%0d exp_last=%0d", bit_out, mon_item.b, bit_last, mon_item.last);
            chk("bit_out", 32'(bit_out), 32'(mon_item.b));
            chk("bit_last", 32'(bit_last), 32'(mon_item.last));
            if (mon_item.last) term_exp = 1'b1;
          end
        end
        prev_stall = bit_valid && !bit_ready;
        prev_bit = bit_out;
      end
    end
  end

  // Downstream ready driver.
  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      bit_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_sym(input logic [N:0] l, input logic [E3_W-1:0] e, input bit fe,
                          output bit captured);
    low = l;
    e3_count = e;
    sym_done = 1'b1;
    force_end = fe;
    captured = fe || (model_count == NUM_SYMBOLS - 1);
    model_count++;
    if (captured) push_message(l, int'(e));
    cycle();
    sym_done = 1'b0;
    force_end = 1'b0;
  endtask

  task automatic send_force(input logic [N:0] l, input logic [E3_W-1:0] e);
    low = l;
    e3_count = e;
    force_end = 1'b1;
    push_message(l, int'(e));
    cycle();
    force_end = 1'b0;
  endtask

  // Called at T+1 (#1 after the capture edge). Counts enc_hold cycles until
  // RUN resumes, optionally injecting illegal sym_done pulses meanwhile.
  task automatic wait_flush(input int e, input bit inject, output int hold_cycles);
    int start_hs;
    start_hs = hs_total;
    chk("enc_hold_start", 32'(enc_hold), 32'd1);
    chk("sym_count_flush", 32'(sym_count), 32'(model_count));
    hold_cycles = 0;
    while (enc_hold && hold_cycles < TIMEOUT) begin
      if (inject && hold_cycles < 2) begin
        sym_done = 1'b1;
        low = LW'($urandom);
        e3_count = E3_W'($urandom);
      end
      hold_cycles++;
      cycle();
      sym_done = 1'b0;
      if (inject && hold_cycles == 2)
        chk("inject_count", 32'(sym_count), 32'(model_count));
    end
    if (hold_cycles >= TIMEOUT) begin
      checks++;
      failures++;
      $display("FAIL flush_timeout: enc_hold still %0d after %0d cycles, required 0", enc_hold, hold_cycles);
    end
    model_count = 0;
    chk("sym_count_after", 32'(sym_count), 32'd0);
    chk("handshakes", 32'(hs_total - start_hs), 32'(N + 1 + e));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("message done: e3=%0d hold_cycles=%0d handshakes=%0d", e, hold_cycles, hs_total - start_hs);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_enc_hold"}, 32'(enc_hold), 32'd0);
    chk({tag, "_bit_out"}, 32'(bit_out), 32'd0);
    chk({tag, "_bit_valid"}, 32'(bit_valid), 32'd0);
    chk({tag, "_bit_last"}, 32'(bit_last), 32'd0);
    chk({tag, "_terminate"}, 32'(terminate_flag), 32'd0);
    chk({tag, "_sym_count"}, 32'(sym_count), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int hc;
    bit cap;
    logic [N:0] l;
    logic [E3_W-1:0] e;
    int k;

    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check_reset_values("reset");
    sys_reset = 1'b1;
    mon_en = 1'b1;
    cycle();
    chk("run_idle_hold", 32'(enc_hold), 32'd0);

    // Forced end, no E3 bits: exactly low, MSB-first
    send_force(9'h1A5, 7'd0);
    wait_flush(0, 1'b0, hc);
    chk("hold_span_e3_0", 32'(hc), 32'(N + 2));

    // Forced end with three E3 bits
    send_force(9'h1A5, 7'd3);
    wait_flush(3, 1'b0, hc);
    chk("hold_span_e3_3", 32'(hc), 32'(N + 2 + 3));

    // Full-length message: capture on the NUM_SYMBOLS-th symbol
    for (int i = 0; i < NUM_SYMBOLS - 1; i++) begin
      send_sym(LW'($urandom), E3_W'($urandom), 1'b0, cap);
    end
    chk("count_before_last", 32'(sym_count), 32'(NUM_SYMBOLS - 1));
    chk("no_hold_before_last", 32'(enc_hold), 32'd0);
    send_sym(9'h0FF, 7'd1, 1'b0, cap);
    wait_flush(1, 1'b0, hc);
    chk("hold_span_full", 32'(hc), 32'(N + 2 + 1));

    // Backpressure across the E3 phase
    stall_en = 1'b1;
    send_force(LW'($urandom), 7'd12);
    wait_flush(12, 1'b0, hc);
    stall_en = 1'b0;

    // force_end together with sym_done at count 10, then illegal sym_done
    for (int i = 0; i < 10; i++) send_sym(LW'($urandom), E3_W'($urandom_range(0, 5)), 1'b0, cap);
    chk("count_10", 32'(sym_count), 32'd10);
    e = 7'd2;
    send_sym(9'h15A, e, 1'b1, cap);
    wait_flush(2, 1'b1, hc);

    // Reset during REM at idx=4
    l = LW'($urandom);
    send_force(l, 7'd0);
    repeat (4) cycle();
    chk("pre_reset_valid", 32'(bit_valid), 32'd1);
    chk("pre_reset_bit", 32'(bit_out), 32'(l[4]));
    mon_en = 1'b0;
    #1;
    sys_reset = 1'b0;
    #1;
    check_reset_values("async_reset");
    exp_q.delete();
    model_count = 0;
    cycle();
    sys_reset = 1'b1;
    mon_en = 1'b1;
    cycle();
    chk("post_reset_hold", 32'(enc_hold), 32'd0);
    send_force(LW'($urandom), 7'd4);
    wait_flush(4, 1'b0, hc);
    chk("hold_span_post_reset", 32'(hc), 32'(N + 2 + 4));

    // Randomised messages
    for (int m = 0; m < 15; m++) begin
      stall_en = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 3) == 0) ? E3_W'($urandom) : E3_W'($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0) begin
        cap = 1'b0;
        while (!cap) begin
          l = LW'($urandom);
          send_sym(l, (model_count == NUM_SYMBOLS - 1) ? e : E3_W'($urandom), 1'b0, cap);
        end
      end else begin
        k = $urandom_range(0, 40);
        for (int i = 0; i < k; i++) send_sym(LW'($urandom), E3_W'($urandom), 1'b0, cap);
        if ($urandom_range(0, 1) == 1) send_force(LW'($urandom), e);
        else send_sym(LW'($urandom), e, 1'b1, cap);
      end
      wait_flush(int'(e), 1'b0, hc);
      if (!stall_en) chk("hold_span_rand", 32'(hc), 32'(N + 2 + int'(e)));
      stall_en = 1'b0;
    end

    repeat (3) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
